// File: rtl/serial_rx_ctrl_pkg.sv
// Shared definitions for the oversampling serial receiver: FSM state
// encoding, baud constants and the per-mode tick divider table.
package serial_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

  localparam int unsigned CLK_HZ     = 50_000_000;

  localparam int unsigned BAUD_38400 = 38400;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_4800  = 4800;

  // Clocks per oversampling tick at 16x, indexed by mode.
  localparam int unsigned DIV_OVS16 [4] = '{81, 163, 326, 651};

  // Wide enough for the slowest divider at the smallest legal OVS (1302).
  localparam int DIV_W = 11;

  function automatic int unsigned baud_for(input logic [1:0] mode);
    case (mode)
      2'd0:    return BAUD_38400;
      2'd1:    return BAUD_19200;
      2'd2:    return BAUD_9600;
      default: return BAUD_4800;
    endcase
  endfunction

  // Clocks per tick for a mode; other OVS values round to the nearest clock.
  function automatic int unsigned div_for(input logic [1:0] mode, input int unsigned ovs);
    int unsigned baud;
    baud = baud_for(mode);
    if (ovs == 16) return DIV_OVS16[mode];
    return (CLK_HZ + (baud * ovs) / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Oversampling tick divider. The baud mode is captured when a frame starts,
// and the divider phase restarts at that moment so ticks line up with the
// start edge.
module serial_tick_gen
  import serial_rx_ctrl_pkg::*;
#(
  parameter int unsigned OVS = 16
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       restart,
  output logic       tick
);

  localparam logic [DIV_W-1:0] TOP_M0 = DIV_W'(div_for(2'd0, OVS) - 1);
  localparam logic [DIV_W-1:0] TOP_M1 = DIV_W'(div_for(2'd1, OVS) - 1);
  localparam logic [DIV_W-1:0] TOP_M2 = DIV_W'(div_for(2'd2, OVS) - 1);
  localparam logic [DIV_W-1:0] TOP_M3 = DIV_W'(div_for(2'd3, OVS) - 1);

  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_top;

  // Terminal count for the mode latched at frame start.
  always_comb begin
    div_top = TOP_M0;
    case (mode_q)
      2'd0:    div_top = TOP_M0;
      2'd1:    div_top = TOP_M1;
      2'd2:    div_top = TOP_M2;
      default: div_top = TOP_M3;
    endcase
  end

  // >= keeps the counter bounded even if it were ever above the terminal count.
  assign tick = (div_cnt >= div_top);

  // Mode latch and divider counter; restart wins over the free-running count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 2'd0;
      div_cnt <= '0;
    end else if (restart) begin
      mode_q  <= mode;
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// 8N1 oversampling UART receiver: input synchronizer, start/data/stop FSM,
// and a one-deep holding register with valid/ready handoff, framing-error
// and overrun pulses.
module serial_rx_ctrl
  import serial_rx_ctrl_pkg::*;
#(
  parameter int unsigned OVS    = 16,
  parameter int unsigned DATA_W = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic [1:0]        mode,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(DATA_W);

  // Saturating increments: counters stop at their last legal value.
  function automatic logic [TW-1:0] tick_inc(input logic [TW-1:0] v);
    return (v >= FULL_LAST) ? FULL_LAST : v + 1'b1;
  endfunction

  function automatic logic [BW-1:0] bit_inc(input logic [BW-1:0] v);
    return (v >= BIT_MAX) ? BIT_MAX : v + 1'b1;
  endfunction

  logic              rxd_p0, rxd_p1, rxd_s;
  logic              fill_p0, fill_p1, armed;
  rx_state_e         state, state_nxt;
  logic [TW-1:0]     tick_cnt, tick_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic              restart, deliver, ferr;
  logic              tick;

  serial_tick_gen #(.OVS(OVS)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .restart (restart),
    .tick    (tick)
  );

  assign rxd_s = rxd_p1;
  assign busy  = (state != ST_IDLE);

  // Synchronizer, plus an arm flag: after reset the line must be seen high
  // once through a filled synchronizer before a start bit is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0  <= 1'b1;
      rxd_p1  <= 1'b1;
      fill_p0 <= 1'b0;
      fill_p1 <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rxd_p0  <= rxd;
      rxd_p1  <= rxd_p0;
      fill_p0 <= 1'b1;
      fill_p1 <= fill_p0;
      if (fill_p1 && rxd_p1) armed <= 1'b1;
    end
  end

  // FSM next-state, counter and shift-register updates.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    restart   = 1'b0;
    deliver   = 1'b0;
    ferr      = 1'b0;
    if (!rx_en) begin
      state_nxt = ST_IDLE;
      tick_nxt  = '0;
      bit_nxt   = '0;
      sh_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed && !rxd_s) begin
            state_nxt = ST_START;
            restart   = 1'b1;
            tick_nxt  = '0;
            bit_nxt   = '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_nxt  = '0;
              state_nxt = rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_nxt = tick_inc(tick_cnt);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_nxt = '0;
              sh_nxt   = {rxd_s, shreg[DATA_W-1:1]};
              bit_nxt  = bit_inc(bit_cnt);
              if (bit_cnt == LAST_BIT) state_nxt = ST_STOP;
            end else begin
              tick_nxt = tick_inc(tick_cnt);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_nxt = '0;
              bit_nxt  = '0;
              if (rxd_s) begin
                deliver   = 1'b1;
                state_nxt = ST_IDLE;
              end else begin
                ferr      = 1'b1;
                sh_nxt    = '0;
                state_nxt = ST_WAIT_HI;
              end
            end else begin
              tick_nxt = tick_inc(tick_cnt);
            end
          end
        end
        ST_WAIT_HI: begin
          if (rxd_s) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          tick_nxt  = '0;
          bit_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
    end
  end

  // Holding register: a new byte loads when the slot is free or being
  // consumed this cycle; otherwise it is dropped and overrun pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= ferr;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (deliver) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl at OVS=16, mostly at 38400 baud.
module tb_serial_rx_ctrl;

  // 16 ticks of 81 clocks per bit at mode 0.
  localparam int BIT0 = 16 * 81;
  // Edge after the drive, two synchronizer flops, then 152 ticks to the stop
  // sample, which loads the holding register on that same edge.
  localparam int LAT0 = 1 + 2 + 152 * 81;
  // A false start is busy for 8 ticks.
  localparam int GLITCH_M0 = 8 * 81;
  localparam int GLITCH_M3 = 8 * 651;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cyc = 0;
  int rv_rise = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  logic rv_q = 1'b0;
  int b0, r0;
  logic [7:0] pat;

  serial_rx_ctrl #(.OVS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en     (rx_en),
    .mode      (mode),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial forever #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rx_valid && !rv_q) begin
      rv_rise++;
      rise_cyc = cyc;
    end
    rv_q = rx_valid;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    @(posedge clk);
    rv_rise = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    busy_cnt = 0;
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, eight data bits LSB first, then the stop level for stop_clks.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_clks);
    t0 = cyc;
    drive_bit(1'b0, BIT0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT0);
    drive_bit(stop_v, stop_clks);
  endtask

  task automatic wait_not_busy(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (5) @(negedge clk);

    // 0x5A at 38400, left unconsumed.
    clr_mon();
    send_frame(8'h5A, 1'b1, BIT0);
    chk("5a_data", 32'(rx_data), 32'h5A);
    chk("5a_valid", 32'(rx_valid), 32'd1);
    chk("5a_latency", 32'(rise_cyc - t0), 32'(LAT0));
    chk("5a_ferr", 32'(fe_cnt), 32'd0);
    chk("5a_busy", 32'(busy), 32'd0);

    // Second byte while the first is still held: dropped with one overrun.
    clr_mon();
    send_frame(8'hA5, 1'b1, BIT0);
    chk("ovr_data_kept", 32'(rx_data), 32'h5A);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_pulse", 32'(ov_cnt), 32'd1);
    chk("ovr_no_reload", 32'(rv_rise), 32'd0);

    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("consume_valid", 32'(rx_valid), 32'd0);
    chk("consume_data", 32'(rx_data), 32'h5A);

    // 20-clock low glitch: false start, back to idle after 8 ticks.
    clr_mon();
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 1000);
    chk("glitch_busy_len", 32'(busy_cnt), 32'(GLITCH_M0));
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(rv_rise), 32'd0);

    // Same glitch at 4800 with mode changed mid-frame: latched divider holds.
    clr_mon();
    mode = 2'd3;
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 80);
    mode = 2'd0;
    drive_bit(1'b1, 5400);
    chk("m3_busy_len", 32'(busy_cnt), 32'(GLITCH_M3));
    chk("m3_idle", 32'(busy), 32'd0);

    // 0x81 with stop low and the line held low three bit times.
    clr_mon();
    send_frame(8'h81, 1'b0, 3 * BIT0);
    chk("ferr_wait_hi", 32'(busy), 32'd1);
    chk("ferr_pulse", 32'(fe_cnt), 32'd1);
    chk("ferr_no_valid", 32'(rv_rise), 32'd0);
    rxd = 1'b1;
    wait_not_busy("ferr_release", 8);
    drive_bit(1'b1, 50);
    chk("ferr_valid", 32'(rx_valid), 32'd0);

    // Disable the receiver halfway through bit 4.
    clr_mon();
    pat = 8'h11;
    drive_bit(1'b0, BIT0);
    for (int i = 0; i < 4; i++) drive_bit(pat[i], BIT0);
    drive_bit(pat[4], BIT0 / 2);
    chk("en_busy_before", 32'(busy), 32'd1);
    rx_en = 1'b0;
    @(negedge clk);
    chk("en_drop_idle", 32'(busy), 32'd0);
    drive_bit(1'b1, 20);
    rx_en = 1'b1;
    drive_bit(1'b1, 20);
    chk("en_no_valid", 32'(rv_rise), 32'd0);
    chk("en_ferr", 32'(fe_cnt), 32'd0);

    clr_mon();
    send_frame(8'h11, 1'b1, BIT0);
    chk("11_data", 32'(rx_data), 32'h11);
    chk("11_valid", 32'(rx_valid), 32'd1);
    chk("11_latency", 32'(rise_cyc - t0), 32'(LAT0));

    // Reset mid-DATA, released while the line is still low.
    drive_bit(1'b0, 2 * BIT0);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", 32'(rx_data), 32'h00);
    chk("rst_mid_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_busy0", 32'(busy), 32'd0);
    chk("rst_mid_ferr", 32'(frame_err), 32'd0);
    chk("rst_mid_ovr", 32'(overrun), 32'd0);
    drive_bit(1'b0, BIT0);
    rst_n = 1'b1;
    b0 = busy_cnt;
    r0 = rv_rise;
    drive_bit(1'b0, 3 * BIT0);
    chk("por_low_idle", 32'(busy), 32'd0);
    drive_bit(1'b1, 100);
    chk("por_no_busy", 32'(busy_cnt - b0), 32'd0);
    chk("por_no_valid", 32'(rv_rise - r0), 32'd0);
    chk("por_valid", 32'(rx_valid), 32'd0);
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 700);
    chk("por_rearmed", 32'(busy_cnt - b0), 32'(GLITCH_M0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
SERIAL_RX_CTRL -- requirements
Module: serial_rx_ctrl

Interface
REQ-001 Parameter OVS, default 16: oversampling ticks per bit; legal range 8..16, even only.
REQ-002 clk  in  1  system clock, 50 MHz.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 rx_en  in  1  receiver enable; low forces IDLE and aborts any frame.
REQ-005 mode  in  2  baud select: 0=38400, 1=19200, 2=9600, 3=4800.
REQ-006 rxd  in  1  asynchronous serial line, idle high.
REQ-007 rx_data  out  8  received byte, LSB first on the line.
REQ-008 rx_valid  out  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  in  1  consumer accepts rx_data on a cycle where rx_valid&&rx_ready.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 frame_err  out  1  one-cycle pulse when the stop bit samples low.
REQ-012 overrun  out  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-013 rxd SHALL pass a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-014 Tick divider SHALL emit a one-cycle tick every DIV[mode] clocks; DIV = {81,163,326,651} for OVS=16.
REQ-015 Divider SHALL restart at 0 on the cycle the FSM leaves IDLE, so tick phase aligns to the start edge.
REQ-016 mode SHALL be latched on leaving IDLE; changes mid-frame have no effect until the next frame.
REQ-017 FSM states: IDLE, START, DATA, STOP, WAIT_HI.
REQ-018 IDLE->START when rx_en && rxd_s==0.
REQ-019 START: at tick OVS/2, rxd_s==0 -> DATA with the tick counter cleared; rxd_s==1 -> IDLE (false start, no output).
REQ-020 DATA: sample rxd_s on every OVS-th tick into shift register bit 7, shifting right; after 8 samples -> STOP.
REQ-021 STOP: on the OVS-th tick, rxd_s==1 -> deliver byte, go IDLE; rxd_s==0 -> pulse frame_err, discard byte, go WAIT_HI.
REQ-022 WAIT_HI -> IDLE on the first cycle rxd_s==1 (break/line-low protection).
REQ-023 Delivery: rx_data/rx_valid update on the clock edge after the stop-bit sample (latency 1 clk).
REQ-024 rx_valid SHALL remain high and rx_data stable until a cycle with rx_ready high.
REQ-025 Delivery with rx_valid==0, or with rx_valid&&rx_ready on that same cycle: load new byte, rx_valid=1.
REQ-026 Delivery with rx_valid&&!rx_ready: keep the old byte, pulse overrun, drop the new byte.
REQ-027 rx_en low in any state: next state IDLE, shift register and tick counter cleared; the holding register and rx_valid are unaffected.
REQ-028 Bit and tick counters SHALL saturate/clear explicitly and never wrap into an undefined state.

Reset
REQ-029 On rst_n low: state=IDLE, rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, overrun=0, synchronizer flops=1, counters=0.
REQ-030 Deassertion mid-line-low SHALL NOT start a frame until rxd_s has been seen high once (power-on in WAIT_HI).

Structure
REQ-031 Shared package holds the state enum, the DIV table per mode, and the 38400/19200/9600/4800 display constants.
REQ-032 One sub-module, serial_tick_gen (divider + mode latch + restart), is instantiated once; the FSM and holding register stay in serial_rx_ctrl.

Verification
REQ-033 mode=0, send 0x5A 8N1 at 38400 -> rx_data=0x5A, rx_valid=1 within 1 clk of the stop-bit middle, frame_err=0.
REQ-034 mode=3, send 0xA5 then 0x3C with rx_ready held 0 -> rx_data stays 0xA5, one overrun pulse at the second stop.
REQ-035 Low glitch of 20 clk on idle line, mode=0 -> START then IDLE, no rx_valid, busy returns 0.
REQ-036 Send 0x81 with stop bit driven 0, line low for 3 bit times -> one frame_err pulse, FSM in WAIT_HI until line high, no rx_valid.
REQ-037 Drop rx_en during bit 4 of a frame -> IDLE next clk, busy=0, no output; the next full frame 0x11 is received correctly.
REQ-038 Assert rst_n low mid-DATA -> all outputs at reset values immediately; frame discarded.
